// File: rtl/bcd_seq_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seq_display
// Purpose  : Sequential binary-to-BCD converter (double dabble, one bit per
//            clock) with a registered active-low seven-segment decode of the
//            result.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst_n      - asynchronous active-low reset
//            start_i    - conversion request, sampled only while idle
//            data_i     - unsigned binary value, captured on acceptance
//            busy_o     - high while a conversion is in progress
//            done_o     - one-cycle pulse; bcd/seg/overflow valid from then on
//            overflow_o - last result did not fit in DIGITS decimal digits
//            bcd_o      - packed BCD result, digit 0 (units) in bits [3:0]
//            seg_o      - active-low segments (gfedcba), digit i in [7i+6:7i]
// Config   : BCD_BLANK_LEADING_ZEROS_EN - when defined, digits above the most
//            significant nonzero digit are blanked (digit 0 is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seq_display #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   seg_o
);

  localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DATA_W);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Single-digit active-low decode, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Full display decode. With blanking enabled, scan from the top digit down
  // and blank zeros until the first nonzero digit; digit 0 always shows.
  function automatic logic [7*DIGITS-1:0] seg_encode(input logic [4*DIGITS-1:0] v);
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_encode = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef BCD_BLANK_LEADING_ZEROS_EN
      if (lead && (i != 0) && (v[4*i +: 4] == 4'd0)) begin
        seg_encode[7*i +: 7] = 7'b1111111;
      end else begin
        lead = 1'b0;
        seg_encode[7*i +: 7] = seg7(v[4*i +: 4]);
      end
`else
      seg_encode[7*i +: 7] = seg7(v[4*i +: 4]);
`endif
    end
  endfunction

  // Display pattern shown while in reset (result value 0).
  localparam logic [7*DIGITS-1:0] c_SEG_RST = seg_encode({(4*DIGITS){1'b0}});

  state_t                state_q;
  logic [DATA_W-1:0]     shreg_q;
  logic [DATA_W-1:0]     shreg_d;
  logic [4*DIGITS-1:0]   work_q;
  logic [4*DIGITS-1:0]   work_adj;
  logic [4*DIGITS-1:0]   work_d;
  logic                  ovf_acc_q;
  logic                  ovf_acc_d;
  logic [c_CNT_W-1:0]    cnt_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [7*DIGITS-1:0]   seg_q;

  // Add-3 correction on every digit >= 5 ahead of the shift.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // One left shift of {working BCD, shift register}. The bit leaving the top
  // digit is a decimal carry out of the DIGITS-digit window, i.e. overflow.
  assign work_d    = {work_adj[4*DIGITS-2:0], shreg_q[DATA_W-1]};
  assign shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
  assign ovf_acc_d = ovf_acc_q | work_adj[4*DIGITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      seg_q     <= c_SEG_RST;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shreg_q   <= data_i;
            work_q    <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= c_CNT_LOAD;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_q   <= shreg_d;
          work_q    <= work_d;
          ovf_acc_q <= ovf_acc_d;
          cnt_q     <= cnt_q - c_CNT_LAST;
          if (cnt_q == c_CNT_LAST) begin
            bcd_q   <= work_d;
            seg_q   <= seg_encode(work_d);
            ovf_q   <= ovf_acc_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == SHIFT);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign bcd_o      = bcd_q;
  assign seg_o      = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seq_display
// Purpose  : Self-checking bench for bcd_seq_display. Two instances share
//            clock and reset: 8-bit/3-digit and 8-bit/2-digit (overflow).
//            Expected results are queued when a start is accepted and
//            compared (value and arrival time) when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_display;

  localparam int c_PERIOD = 10;
  localparam int c_DW     = 8;

  typedef struct {
    longint      t;
    logic [11:0] bcd;
    logic        ovf;
    logic [20:0] seg;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        start1, start2;
  logic [7:0]  data1, data2;
  logic        busy1, busy2, done1, done2, ovf1, ovf2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;
  logic [20:0] seg1;
  logic [13:0] seg2;

  int    checks = 0;
  int    errors = 0;
  item_t q1[$];
  item_t q2[$];
  item_t it1, it2;
  logic [11:0] last_bcd1 = '0;

  bcd_seq_display #(.DATA_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .data_i(data1),
    .busy_o(busy1), .done_o(done1), .overflow_o(ovf1), .bcd_o(bcd1), .seg_o(seg1)
  );

  bcd_seq_display #(.DATA_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .data_i(data2),
    .busy_o(busy2), .done_o(done2), .overflow_o(ovf2), .bcd_o(bcd2), .seg_o(seg2)
  );

  initial clk = 1'b0;
  always #(c_PERIOD/2) clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference result for value val on a display of the given digit count.
  function automatic item_t make_item(input int val, input int digits, input longint t_acc);
    item_t it;
    int pw, v, msd;
    int dg[10];
    pw = 1;
    for (int i = 0; i < digits; i++) pw = pw * 10;
    it.t   = t_acc + c_DW * c_PERIOD + c_PERIOD / 2;
    it.ovf = (val >= pw);
    it.bcd = '0;
    it.seg = '0;
    v      = val % pw;
    msd    = 0;
    for (int i = 0; i < digits; i++) begin
      dg[i] = v % 10;
      v     = v / 10;
      it.bcd[4*i +: 4] = 4'(dg[i]);
      if (dg[i] != 0) msd = i;
    end
    for (int i = 0; i < digits; i++) begin
`ifdef BCD_BLANK_LEADING_ZEROS_EN
      if (i > msd) it.seg[7*i +: 7] = 7'b1111111;
      else         it.seg[7*i +: 7] = seg_ref(dg[i]);
`else
      it.seg[7*i +: 7] = seg_ref(dg[i]);
`endif
    end
    return it;
  endfunction

  // Done monitors: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        check("d1_spurious_done", 1, 0);
      end else begin
        it1 = q1.pop_front();
        check("d1_time", $time, it1.t);
        check("d1_bcd",  bcd1,  it1.bcd);
        check("d1_ovf",  ovf1,  it1.ovf);
        check("d1_seg",  seg1,  it1.seg);
        last_bcd1 = it1.bcd;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        check("d2_spurious_done", 1, 0);
      end else begin
        it2 = q2.pop_front();
        check("d2_time", $time, it2.t);
        check("d2_bcd",  bcd2,  it2.bcd[7:0]);
        check("d2_ovf",  ovf2,  it2.ovf);
        check("d2_seg",  seg2,  it2.seg[13:0]);
      end
    end
  end

  // Called at a negedge with the selected instances idle.
  task automatic convert(input bit e1, input bit e2, input int v1, input int v2);
    if (e1) begin data1 = 8'(v1); start1 = 1'b1; end
    if (e2) begin data2 = 8'(v2); start2 = 1'b1; end
    @(posedge clk);
    if (e1) q1.push_back(make_item(v1, 3, $time));
    if (e2) q2.push_back(make_item(v2, 2, $time));
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q2.size() != 0) begin
      check("done_timeout", q1.size() + q2.size(), 0);
      q1.delete();
      q2.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    item_t z1, z2;
    int    bcnt;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; data1 = '0; data2 = '0;
    z1 = make_item(0, 3, 0);
    z2 = make_item(0, 2, 0);
    repeat (2) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_ovf",  ovf1,  0);
    check("rst_bcd",  bcd1,  0);
    check("rst_seg",  seg1,  z1.seg);
    check("rst_seg2", seg2,  z2.seg[13:0]);
    rst_n = 1'b1;

    // 255: accepted on the first edge after reset, busy for 8 cycles.
    convert(1, 0, 255, 0);
    bcnt = busy1 ? 1 : 0;
    repeat (12) begin
      @(negedge clk);
      if (busy1) bcnt++;
    end
    check("busy_len", bcnt, 8);
    wait_idle();

    // Zero on both displays.
    convert(1, 1, 0, 0);
    wait_idle();

    // start held high: 9 then 128, data change mid-conversion ignored.
    data1 = 8'd9; start1 = 1'b1;
    @(posedge clk);
    q1.push_back(make_item(9, 3, $time));
    @(negedge clk);
    data1 = 8'd128;
    repeat (9) @(posedge clk);
    q1.push_back(make_item(128, 3, $time));
    @(negedge clk);
    start1 = 1'b0;
    wait_idle();

    // Two-digit overflow boundaries.
    convert(0, 1, 0, 200);
    wait_idle();
    convert(0, 1, 0, 99);
    wait_idle();
    convert(0, 1, 0, 100);
    wait_idle();

    // Outputs hold between done pulses.
    repeat (5) @(negedge clk);
    check("hold_bcd", bcd1, last_bcd1);

    // Random values on both instances.
    for (int k = 0; k < 6; k++) begin
      convert(1, 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      wait_idle();
    end

    // Reset mid-conversion aborts without a done pulse.
    convert(1, 0, 173, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_bcd",  bcd1,  0);
    check("abort_ovf",  ovf1,  0);
    check("abort_seg",  seg1,  z1.seg);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_hold_bcd", bcd1, 0);
    convert(1, 0, 173, 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
